// File: rtl/rr_onehot_arbiter_pkg.sv
// Shared definitions for the round-robin one-hot arbiter.
//   rra_state_t   : arbiter FSM states (idle / holding a live grant)
//   RRA_MAX_W     : widest one-hot vector onehot_to_idx accepts
//   onehot_to_idx : binary position of the set bit of a one-hot vector
//                   (0 for an all-zero vector)
package rr_onehot_arbiter_pkg;

   typedef enum logic {RRA_IDLE, RRA_HOLD} rra_state_t;

   localparam int RRA_MAX_W = 64;

   // OR-reduction of the positions of the set bits. This is exact for one-hot
   // inputs and needs no priority chain.
   function automatic int onehot_to_idx(input logic [RRA_MAX_W-1:0] oh);
      int idx;
      idx = 0;
      for (int i = 0; i < RRA_MAX_W; i++) begin
         if (oh[i]) idx = idx | i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_onehot_arbiter_find_first.sv
// Circular find-first selector (purely combinational).
//   req    [WIDTH]        : candidate vector
//   ptr    [clog2(WIDTH)] : position with the highest priority
//   onehot [WIDTH]        : first set bit of req scanning ptr, ptr+1, ... wrapping
//   found                 : req has at least one set bit
module rr_find_first
   import rr_onehot_arbiter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]         req,
   input  logic [$clog2(WIDTH)-1:0] ptr,
   output logic [WIDTH-1:0]         onehot,
   output logic                     found
);

   logic [2*WIDTH-1:0] doubled;
   logic [2*WIDTH-1:0] mask;
   logic [2*WIDTH-1:0] masked;
   logic [2*WIDTH-1:0] first;

   // The upper copy of req stays unmasked, so a requester below ptr is still
   // found after the scan wraps. x & -x isolates the lowest set bit, and
   // folding the two halves together maps that bit back into WIDTH positions.
   always_comb begin
      doubled = {req, req};
      mask    = ~(((2*WIDTH)'(1) << ptr) - (2*WIDTH)'(1));
      masked  = doubled & mask;
      first   = masked & (~masked + (2*WIDTH)'(1));
      onehot  = first[WIDTH-1:0] | first[2*WIDTH-1:WIDTH];
      found   = |req;
   end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant and valid/ready handshake.
//   clk          : clock, all state updates on posedge
//   rst          : synchronous reset, active-high
//   req          : request vector, any pattern legal
//   flush        : kills the pending grant; pointer is kept
//   grant_ready  : consumer accepts the current grant
//   grant_valid  : grant_onehot/grant_index hold a live grant
//   grant_onehot : registered one-hot grant, zero when not valid
//   grant_index  : binary index of the grant, zero when not valid
//   rr_ptr       : current highest-priority position
// WIDTH must be a power of two, between 2 and RRA_MAX_W.
module rr_onehot_arbiter
   import rr_onehot_arbiter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         req,
   input  logic                     flush,
   input  logic                     grant_ready,
   output logic                     grant_valid,
   output logic [WIDTH-1:0]         grant_onehot,
   output logic [$clog2(WIDTH)-1:0] grant_index,
   output logic [$clog2(WIDTH)-1:0] rr_ptr
);

   localparam int IDX_W = $clog2(WIDTH);

   rra_state_t       state_p1, state_nxt;
   logic [WIDTH-1:0] grant_oh_p1, grant_oh_nxt;
   logic [IDX_W-1:0] grant_idx_p1, grant_idx_nxt;
   logic [IDX_W-1:0] ptr_p1, ptr_nxt;
   logic [IDX_W-1:0] idx_inc;
   logic [IDX_W-1:0] arb_ptr;
   logic [IDX_W-1:0] win_idx;
   logic [WIDTH-1:0] win_oh;
   logic             win_found;
   logic             handshake;

   // A flush outranks the handshake, so a flushed grant never counts as consumed.
   assign handshake = (state_p1 == RRA_HOLD) && grant_ready && !flush;
   // WIDTH is a power of two, so the natural wrap of IDX_W bits is the modulo.
   assign idx_inc   = grant_idx_p1 + IDX_W'(1);
   // On a handshake, arbitration already uses the advanced pointer. This keeps
   // back-to-back grants fair at one grant per cycle.
   assign arb_ptr   = handshake ? idx_inc : ptr_p1;

   rr_find_first #(
      .WIDTH (WIDTH)
   ) u_find_first (
      .req    (req),
      .ptr    (arb_ptr),
      .onehot (win_oh),
      .found  (win_found)
   );

   assign win_idx = IDX_W'(onehot_to_idx(RRA_MAX_W'(win_oh)));

   always_comb begin
      state_nxt     = state_p1;
      grant_oh_nxt  = grant_oh_p1;
      grant_idx_nxt = grant_idx_p1;
      ptr_nxt       = ptr_p1;
      if (flush) begin
         state_nxt     = RRA_IDLE;
         grant_oh_nxt  = '0;
         grant_idx_nxt = '0;
      end else begin
         case (state_p1)
            RRA_IDLE: begin
               if (win_found) begin
                  state_nxt     = RRA_HOLD;
                  grant_oh_nxt  = win_oh;
                  grant_idx_nxt = win_idx;
               end
            end
            RRA_HOLD: begin
               // Without ready the grant is sticky, even if its request drops.
               if (grant_ready) begin
                  ptr_nxt = idx_inc;
                  if (win_found) begin
                     grant_oh_nxt  = win_oh;
                     grant_idx_nxt = win_idx;
                  end else begin
                     state_nxt     = RRA_IDLE;
                     grant_oh_nxt  = '0;
                     grant_idx_nxt = '0;
                  end
               end
            end
            default: begin
               state_nxt     = RRA_IDLE;
               grant_oh_nxt  = '0;
               grant_idx_nxt = '0;
            end
         endcase
      end
   end

   // ---- stage p1: grant / pointer registers ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state_p1     <= RRA_IDLE;
         grant_oh_p1  <= '0;
         grant_idx_p1 <= '0;
         ptr_p1       <= '0;
      end else begin
         state_p1     <= state_nxt;
         grant_oh_p1  <= grant_oh_nxt;
         grant_idx_p1 <= grant_idx_nxt;
         ptr_p1       <= ptr_nxt;
      end
   end

   assign grant_valid  = (state_p1 == RRA_HOLD);
   assign grant_onehot = grant_oh_p1;
   assign grant_index  = grant_idx_p1;
   assign rr_ptr       = ptr_p1;

endmodule
